fma16_sched: RTL and testbench
==============================

Name: fma16_sched

Overview:
- Shares one fma16 datapath between NREQ requesters, which present operations over per-requester valid/ready channels.
- Each cycle a round-robin arbiter grants at most one request and drives the operands into the shared datapath, whose pipeline depth is LAT cycles.
- Results are tagged with the requester index and queued in a response FIFO.
- Issue is credit-limited, so a result is never dropped when requesters stall their responses.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LAT, 2, cycles from fma_issue to the matching fma_result (1..4).
- RDEPTH, LAT+2, response FIFO depth in entries (must be greater than LAT).
- TAGW, $clog2(NREQ), requester tag width (derived; not overridden).

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  request pending, one bit per requester.
- req_ready  out  NREQ  one-hot grant; the request is accepted this cycle.
- req_x  in  16*NREQ  x operands (requester i occupies bits [16i+15:16i]).
- req_y  in  16*NREQ  y operands.
- req_z  in  16*NREQ  z operands.
- req_ctl  in  6*NREQ  per requester: {mul, add, negp, negz, roundmode[1:0]}.
- fma_issue  out  1  operands valid to the datapath.
- fma_x, fma_y, fma_z  out  16 each  operands of the selected requester.
- fma_ctl  out  6  control field of the selected requester.
- fma_result  in  16  datapath result, valid LAT cycles after issue.
- fma_flags  in  4  {nv, of, uf, nx}, aligned with fma_result.
- rsp_valid  out  NREQ  one-hot: the FIFO head belongs to requester i.
- rsp_ready  in  NREQ  requester i consumes the head.
- rsp_result  out  16  head result (broadcast to all requesters).
- rsp_flags  out  4  head flags (broadcast).
- busy  out  1  work is in flight or the FIFO is non-empty.

Behaviour:
- Reset values:
  - Outputs: req_ready=0, fma_issue=0, rsp_valid=0, busy=0.
  - State: FIFO empty, in-flight count 0, tag pipe valid bits 0, rr pointer 0.
  - fma_x/fma_y/fma_z/fma_ctl are don't-care while fma_issue=0; reset drives them to 0.
- Credit rule:
  - credit = RDEPTH - (fifo_count + inflight).
  - Issue is allowed only if credit>0.
  - A FIFO pop in the same cycle does not add credit until the next cycle; the rule is conservative by design.
- Arbitration (combinational grant, registered pointer):
  - Search req_valid starting at rr_ptr, wrapping modulo NREQ.
  - The first set bit wins; req_ready is one-hot for it when issue is allowed, otherwise req_ready=0.
  - On a grant to requester g, rr_ptr <= (g+1) mod NREQ. With no grant, rr_ptr holds.
- Issue path:
  - fma_issue = |req_ready, in the same cycle as the handshake (zero-latency mux, no register).
  - The operands/ctl are requester g's slices.
- Tag pipeline: an LAT-stage shift register of {valid, tag}.
  - Stage 0 loads {fma_issue, g}; it shifts every cycle and never stalls, because the datapath has no stall input.
  - inflight = number of valid stages.
- Capture: when the last stage is valid, write {tag, fma_result, fma_flags} into the FIFO. The credit rule guarantees the FIFO is never full at a write.
- Response:
  - The FIFO head drives rsp_valid[tag]=1 while the FIFO is non-empty.
  - Pop when rsp_ready[tag] is high. rsp_ready bits for other requesters are ignored.
  - Responses are returned strictly in issue order; a stalled head blocks all requesters (head-of-line blocking accepted).
- Simultaneous FIFO write and pop:
  - count stays the same; both pointers advance.
  - If the FIFO is empty, the written entry appears at the head the next cycle (no bypass).
- Pointer wrap: FIFO pointers wrap modulo RDEPTH, and RDEPTH need not be a power of 2.
  - Keep the count explicitly.
- busy = |tag valid bits | (fifo_count != 0).
- Reset asserted mid-operation:
  - All in-flight tags and queued results are discarded immediately (asynchronous).
  - Datapath results that arrive after reset is released are ignored, because the tag valid bits are 0.
- Illegal: a requester that drops req_valid without a grant is permitted; the request is simply withdrawn.

Optional Feature:
- Macro FMA16_SCHED_STATS_EN.
- When defined:
  - Adds output grant_cnt [16*NREQ]: per-requester saturating 16-bit grant counters.
  - Adds output stall_cnt [16]: saturating count of cycles with |req_valid=1 and credit=0.
  - Both counters are cleared by reset_n.
- When undefined: these ports and their logic are absent, and the core behaviour is identical.

Test Plan:
- Single request: NREQ=4, LAT=2, requester 2 sends x=0x3C00, y=0x4000, z=0x0000, mul=1 -> req_ready=0b0100 in cycle 0, fma_issue=1 in cycle 0. The model returns 0x4000 at cycle 2; rsp_valid=0b0100 and rsp_result=0x4000 at cycle 3.
- Round-robin fairness: all 4 req_valid held high with rsp_ready all 1 -> grant order 0,1,2,3,0,1, one grant per cycle. Each requester receives 2 responses after 8 cycles of requests.
- Backpressure: rsp_ready=0 with continuous requests -> exactly RDEPTH=4 issues, then req_ready=0 and busy=1. Raising rsp_ready resumes issue, with no result lost or reordered.
- Simultaneous write/pop: FIFO holds 1 entry, and a capture and a pop occur in the same cycle -> count stays 1 and the new head is the captured result.
- Reset mid-flight: assert reset_n=0 with 2 tags in flight and 1 queued result -> rsp_valid=0 and busy=0 immediately. After release, no stale rsp_valid occurs.
- With FMA16_SCHED_STATS_EN: run the backpressure case -> grant_cnt[0..3] sum to 4 and stall_cnt equals the cycles spent blocked.

Source files
------------

// File: rtl/fma16_sched.sv
// fma16_sched: round-robin scheduler that shares one fma16 datapath between NREQ requesters.
// Issue is credit-limited against a tagged in-order response FIFO. Optional stats: FMA16_SCHED_STATS_EN.
module fma16_sched #(
  parameter int NREQ   = 4,
  parameter int LAT    = 2,
  parameter int RDEPTH = LAT + 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [16*NREQ-1:0]   req_x,
  input  logic [16*NREQ-1:0]   req_y,
  input  logic [16*NREQ-1:0]   req_z,
  input  logic [6*NREQ-1:0]    req_ctl,
  output logic                 fma_issue,
  output logic [15:0]          fma_x,
  output logic [15:0]          fma_y,
  output logic [15:0]          fma_z,
  output logic [5:0]           fma_ctl,
  input  logic [15:0]          fma_result,
  input  logic [3:0]           fma_flags,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [15:0]          rsp_result,
  output logic [3:0]           rsp_flags,
  output logic                 busy
`ifdef FMA16_SCHED_STATS_EN
  ,
  output logic [16*NREQ-1:0]   grant_cnt,
  output logic [15:0]          stall_cnt
`endif
);

  localparam int TAGW = $clog2(NREQ);
  localparam int PW   = (RDEPTH > 1) ? $clog2(RDEPTH) : 1;
  localparam int CW   = $clog2(RDEPTH + 1);
  localparam int EW   = TAGW + 20;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(RDEPTH);

  logic [15:0] x_arr [NREQ];
  logic [15:0] y_arr [NREQ];
  logic [15:0] z_arr [NREQ];
  logic [5:0]  c_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign x_arr[i] = req_x[16*i +: 16];
    assign y_arr[i] = req_y[16*i +: 16];
    assign z_arr[i] = req_z[16*i +: 16];
    assign c_arr[i] = req_ctl[6*i +: 6];
  end

  logic [TAGW-1:0]            rr_q, rr_d;
  logic [LAT-1:0]             vld_q, vld_d;
  logic [LAT-1:0][TAGW-1:0]   tag_q, tag_d;
  logic [LAT:0]               vld_cat;
  logic [LAT:0][TAGW-1:0]     tag_cat;
  logic [EW-1:0]              mem_q [RDEPTH];
  logic [PW-1:0]              wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]              cnt_q, cnt_d;

  logic [CW:0]     occ;
  logic            credit_ok, issue_ok;
  logic            gnt_vld;
  logic [TAGW-1:0] gnt_idx, cand;
  logic            wr_en, pop, nonempty;
  logic [EW-1:0]   wr_data, head;
  logic [TAGW-1:0] head_tag;

  // Occupancy counts queued results plus every valid pipe stage; a same-cycle pop is not credited.
  assign occ       = {1'b0, cnt_q} + (CW+1)'($countones(vld_q));
  assign credit_ok = occ < DEPTH_C;
  assign issue_ok  = credit_ok & reset_n;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = rr_q;
    cand    = rr_q;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = TAGW'((32'(rr_q) + i) % NREQ);
      if (!gnt_vld && req_valid[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
    gnt_vld = gnt_vld & issue_ok;
  end

  assign req_ready = gnt_vld ? (NREQ'(1) << gnt_idx) : '0;
  assign fma_issue = gnt_vld;
  assign fma_x     = gnt_vld ? x_arr[gnt_idx] : '0;
  assign fma_y     = gnt_vld ? y_arr[gnt_idx] : '0;
  assign fma_z     = gnt_vld ? z_arr[gnt_idx] : '0;
  assign fma_ctl   = gnt_vld ? c_arr[gnt_idx] : '0;

  always_comb begin
    rr_d = rr_q;
    if (gnt_vld) rr_d = (gnt_idx == TAGW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

  // Concatenating the new stage below the old ones keeps the shift valid for LAT=1.
  assign vld_cat = {vld_q, fma_issue};
  assign tag_cat = {tag_q, gnt_idx};
  assign vld_d   = vld_cat[LAT-1:0];
  assign tag_d   = tag_cat[LAT-1:0];

  assign wr_en    = vld_q[LAT-1];
  assign wr_data  = {tag_q[LAT-1], fma_result, fma_flags};
  assign head     = mem_q[rptr_q];
  assign head_tag = head[EW-1:20];
  assign nonempty = (cnt_q != '0);
  assign pop      = nonempty & rsp_ready[head_tag];

  assign rsp_valid  = nonempty ? (NREQ'(1) << head_tag) : '0;
  assign rsp_result = head[19:4];
  assign rsp_flags  = head[3:0];
  assign busy       = (|vld_q) | nonempty;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wptr_d = wr_en ? ptr_inc(wptr_q) : wptr_q;
    rptr_d = pop ? ptr_inc(rptr_q) : rptr_q;
    cnt_d  = cnt_q + CW'(wr_en) - CW'(pop);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_q   <= '0;
      vld_q  <= '0;
      tag_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      rr_q   <= rr_d;
      vld_q  <= vld_d;
      tag_q  <= tag_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= wr_data;
  end

`ifdef FMA16_SCHED_STATS_EN
  logic [NREQ-1:0][15:0] gcnt_q;
  logic [15:0]           stall_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gcnt_q  <= '0;
      stall_q <= '0;
    end else begin
      if (gnt_vld && (gcnt_q[gnt_idx] != '1)) gcnt_q[gnt_idx] <= gcnt_q[gnt_idx] + 16'd1;
      if ((|req_valid) && !credit_ok && (stall_q != '1)) stall_q <= stall_q + 16'd1;
    end
  end

  assign grant_cnt = gcnt_q;
  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_fma16_sched.sv
// Bench for fma16_sched (NREQ=4, LAT=2, RDEPTH=4) with a stub datapath and a queue-based reference.
module tb_fma16_sched;
  localparam int NREQ   = 4;
  localparam int LAT    = 2;
  localparam int RDEPTH = 4;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ-1:0]     req_ready;
  logic [16*NREQ-1:0]  req_x = '0, req_y = '0, req_z = '0;
  logic [6*NREQ-1:0]   req_ctl = '0;
  logic                fma_issue;
  logic [15:0]         fma_x, fma_y, fma_z;
  logic [5:0]          fma_ctl;
  logic [15:0]         fma_result = '0;
  logic [3:0]          fma_flags = '0;
  logic [NREQ-1:0]     rsp_valid;
  logic [NREQ-1:0]     rsp_ready = '0;
  logic [15:0]         rsp_result;
  logic [3:0]          rsp_flags;
  logic                busy;
`ifdef FMA16_SCHED_STATS_EN
  logic [16*NREQ-1:0]  grant_cnt;
  logic [15:0]         stall_cnt;
`endif

  fma16_sched #(.NREQ(NREQ), .LAT(LAT), .RDEPTH(RDEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_z(req_z), .req_ctl(req_ctl),
    .fma_issue(fma_issue), .fma_x(fma_x), .fma_y(fma_y), .fma_z(fma_z), .fma_ctl(fma_ctl),
    .fma_result(fma_result), .fma_flags(fma_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .busy(busy)
`ifdef FMA16_SCHED_STATS_EN
    , .grant_cnt(grant_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    logic [15:0] res;
    logic [3:0]  flg;
    int          done;
  } ent_t;

  typedef struct {
    logic [3:0] rv;
    logic [3:0] rdy;
    logic [3:0] ready;
    logic [3:0] rspv;
    logic       busy;
  } vec_t;

  int total = 0, bad = 0, cyc = 0;
  int rr_m = 0;
  int rsp_cnt [NREQ];
  logic [15:0] opx [NREQ], opy [NREQ], opz [NREQ];
  logic [5:0]  opc [NREQ];
  logic [15:0] dp_res [8];
  logic [3:0]  dp_flg [8];
  ent_t infl_q [$];
  ent_t fifo_q [$];
  vec_t tbl [12];

  function automatic void chk(string n, int unsigned act, int unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", n, cyc, act, exp);
    end
  endfunction

  // Stand-in for the fma16 unit: exact for 1.0*y+0, an arbitrary mix otherwise.
  function automatic logic [19:0] dp_model(input logic [15:0] x, input logic [15:0] y,
                                           input logic [15:0] z, input logic [5:0] c);
    logic [15:0] r;
    r = (x == 16'h3C00 && z == 16'h0000) ? y : ((x ^ {y[7:0], y[15:8]}) + z + {10'b0, c});
    return {x[3:0] ^ c[3:0], r};
  endfunction

  task automatic step(input logic [NREQ-1:0] rv, input logic [NREQ-1:0] rdy);
    int g, idx;
    logic [19:0] f;
    @(negedge clk);
    req_valid  = rv;
    rsp_ready  = rdy;
    req_x      = {opx[3], opx[2], opx[1], opx[0]};
    req_y      = {opy[3], opy[2], opy[1], opy[0]};
    req_z      = {opz[3], opz[2], opz[1], opz[0]};
    req_ctl    = {opc[3], opc[2], opc[1], opc[0]};
    fma_result = dp_res[cyc % 8];
    fma_flags  = dp_flg[cyc % 8];
    #1;
    g = -1;
    if (fifo_q.size() + infl_q.size() < RDEPTH)
      for (int k = 0; k < NREQ; k++) begin
        idx = (rr_m + k) % NREQ;
        if (g < 0 && rv[idx]) g = idx;
      end
    chk("req_ready", req_ready, (g >= 0) ? (1 << g) : 0);
    chk("fma_issue", fma_issue, (g >= 0) ? 1 : 0);
    if (g >= 0) begin
      chk("fma_x", fma_x, opx[g]);
      chk("fma_y", fma_y, opy[g]);
      chk("fma_z", fma_z, opz[g]);
      chk("fma_ctl", fma_ctl, opc[g]);
    end
    if (fifo_q.size() != 0) begin
      chk("rsp_valid", rsp_valid, 1 << fifo_q[0].tag);
      chk("rsp_result", rsp_result, fifo_q[0].res);
      chk("rsp_flags", rsp_flags, fifo_q[0].flg);
    end else begin
      chk("rsp_valid", rsp_valid, 0);
    end
    chk("busy", busy, (fifo_q.size() + infl_q.size() != 0) ? 1 : 0);
    for (int i = 0; i < NREQ; i++)
      if (rsp_valid[i] && rsp_ready[i]) rsp_cnt[i]++;
    if (fma_issue) begin
      f = dp_model(fma_x, fma_y, fma_z, fma_ctl);
      dp_res[(cyc + LAT) % 8] = f[15:0];
      dp_flg[(cyc + LAT) % 8] = f[19:16];
    end
    if (fifo_q.size() != 0 && rdy[fifo_q[0].tag]) void'(fifo_q.pop_front());
    if (infl_q.size() != 0 && infl_q[0].done == cyc) fifo_q.push_back(infl_q.pop_front());
    if (g >= 0) begin
      f = dp_model(opx[g], opy[g], opz[g], opc[g]);
      infl_q.push_back('{tag: g, res: f[15:0], flg: f[19:16], done: cyc + LAT});
      rr_m = (g + 1) % NREQ;
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_valid = '0;
    rsp_ready = '0;
    reset_n   = 1'b0;
    infl_q.delete();
    fifo_q.delete();
    rr_m = 0;
    cyc++;
    @(negedge clk);
    reset_n = 1'b1;
    cyc++;
  endtask

  initial begin
    logic [19:0] f;
    int sum;
    for (int i = 0; i < 8; i++) begin dp_res[i] = '0; dp_flg[i] = '0; end
    for (int i = 0; i < NREQ; i++) begin
      opx[i] = 16'h1100 * 16'(i + 1);
      opy[i] = 16'h0203 + 16'(i);
      opz[i] = 16'h0040 * 16'(i + 1);
      opc[i] = 6'(i + 9);
      rsp_cnt[i] = 0;
    end
    tbl[0]  = '{4'hF, 4'h0, 4'h1, 4'h0, 1'b0};
    tbl[1]  = '{4'hF, 4'h0, 4'h2, 4'h0, 1'b1};
    tbl[2]  = '{4'hF, 4'h0, 4'h4, 4'h0, 1'b1};
    tbl[3]  = '{4'hF, 4'h0, 4'h8, 4'h1, 1'b1};
    tbl[4]  = '{4'hF, 4'h0, 4'h0, 4'h1, 1'b1};
    tbl[5]  = '{4'hF, 4'h0, 4'h0, 4'h1, 1'b1};
    tbl[6]  = '{4'hF, 4'h0, 4'h0, 4'h1, 1'b1};
    tbl[7]  = '{4'hF, 4'hF, 4'h0, 4'h1, 1'b1};
    tbl[8]  = '{4'hF, 4'hF, 4'h1, 4'h2, 1'b1};
    tbl[9]  = '{4'hF, 4'hF, 4'h2, 4'h4, 1'b1};
    tbl[10] = '{4'hF, 4'hF, 4'h4, 4'h8, 1'b1};
    tbl[11] = '{4'hF, 4'hF, 4'h8, 4'h1, 1'b1};

    // Reset values, with requests pending during reset.
    @(negedge clk);
    req_valid = '1;
    cyc++;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_fma_issue", fma_issue, 0);
    chk("rst_fma_x", fma_x, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    do_reset();

    // Single request from requester 2.
    opx[2] = 16'h3C00; opy[2] = 16'h4000; opz[2] = 16'h0000; opc[2] = 6'b100000;
    step(4'b0100, 4'h0);
    chk("single_ready", req_ready, 4'b0100);
    chk("single_issue", fma_issue, 1);
    step(4'h0, 4'h0);
    step(4'h0, 4'h0);
    step(4'h0, 4'b0100);
    chk("single_rspv", rsp_valid, 4'b0100);
    chk("single_result", rsp_result, 16'h4000);
    step(4'h0, 4'h0);
    chk("single_idle", busy, 0);

    // Backpressure then release.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].rv, tbl[i].rdy);
      chk("tbl_ready", req_ready, tbl[i].ready);
      chk("tbl_rspv", rsp_valid, tbl[i].rspv);
      chk("tbl_busy", busy, tbl[i].busy);
`ifdef FMA16_SCHED_STATS_EN
      if (i == 8) begin
        sum = 0;
        for (int r = 0; r < NREQ; r++) sum += int'(grant_cnt[16*r +: 16]);
        chk("stats_grants", sum, 4);
        chk("stats_stall", stall_cnt, 4);
      end
`endif
    end
    for (int i = 0; i < 10; i++) step(4'h0, 4'hF);

    // Round-robin fairness: 8 request cycles, two responses each.
    do_reset();
    for (int i = 0; i < NREQ; i++) rsp_cnt[i] = 0;
    for (int i = 0; i < 8; i++) step(4'hF, 4'hF);
    for (int i = 0; i < 8; i++) step(4'h0, 4'hF);
    for (int i = 0; i < NREQ; i++) chk("fair_rsp_cnt", rsp_cnt[i], 2);

    // Capture and pop in the same cycle with one entry queued.
    do_reset();
    step(4'b0010, 4'h0);
    step(4'b0001, 4'h0);
    step(4'h0, 4'h0);
    step(4'h0, 4'hF);
    chk("wp_pop_rspv", rsp_valid, 4'b0010);
    step(4'h0, 4'h0);
    f = dp_model(opx[0], opy[0], opz[0], opc[0]);
    chk("wp_head_rspv", rsp_valid, 4'b0001);
    chk("wp_head_result", rsp_result, f[15:0]);
    step(4'h0, 4'h0);
    chk("wp_count_one", rsp_valid, 4'b0001);
    step(4'h0, 4'hF);
    step(4'h0, 4'h0);
    chk("wp_empty", busy, 0);

    // Reset with two tags in flight and one queued result.
    do_reset();
    for (int i = 0; i < 3; i++) step(4'hF, 4'h0);
    @(negedge clk);
    req_valid = 4'hF;
    rsp_ready = 4'h0;
    #1;
    chk("mid_pre_busy", busy, 1);
    chk("mid_pre_rspv", rsp_valid, 4'b0001);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_rspv", rsp_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", req_ready, 0);
    infl_q.delete();
    fifo_q.delete();
    rr_m = 0;
    cyc++;
    @(negedge clk);
    req_valid = '0;
    reset_n = 1'b1;
    cyc++;
    for (int i = 0; i < 6; i++) step(4'h0, 4'hF);

    // Randomized traffic.
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        opx[i] = 16'($urandom);
        opy[i] = 16'($urandom);
        opz[i] = 16'($urandom);
        opc[i] = 6'($urandom);
      end
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15)));
    end
    for (int i = 0; i < 20; i++) step(4'h0, 4'hF);
    chk("rand_drained", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
